instr_feeder: RTL

Sequencing initiator that drives the processor's instruction side: it stores a short program of 16-bit words and issues them one at a time on DIN/Run, waiting for the processor's Done before issuing the next. It replaces hand-set switches and a Run key with an automatic source, so a whole program can execute from one Start pulse. It also handles the two-word mvi format by presenting the immediate word in the cycle after Run.

---
 rtl/instr_feeder_if.sv | 37 +++
 rtl/instr_feeder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/instr_feeder_if.sv
// rtl/instr_feeder_if.sv - instruction-feeder bus: program load, start/len, DIN/Run issue and Done return.
// Step exists only when FEEDER_STEP_EN is defined.
interface instr_feeder_if #(
  parameter int AW = 4
);
  logic          Start;
  logic [AW:0]   Len;
  logic          Wr_En;
  logic [AW-1:0] Wr_Addr;
  logic [15:0]   Wr_Data;
  logic          Done;
`ifdef FEEDER_STEP_EN
  logic          Step;
`endif
  logic [15:0]   DIN;
  logic          Run;
  logic          Busy;
  logic          Finished;
  logic          Error;
  logic [AW:0]   PC;

  modport master (
`ifdef FEEDER_STEP_EN
    input  Step,
`endif
    input  Start, Len, Wr_En, Wr_Addr, Wr_Data, Done,
    output DIN, Run, Busy, Finished, Error, PC
  );

  modport slave (
`ifdef FEEDER_STEP_EN
    output Step,
`endif
    output Start, Len, Wr_En, Wr_Addr, Wr_Data, Done,
    input  DIN, Run, Busy, Finished, Error, PC
  );
endinterface

// File: rtl/instr_feeder.sv
// rtl/instr_feeder.sv - stored-program instruction source issuing words on DIN/Run, paced by Done.
// FEEDER_STEP_EN adds a HOLD state released by Step after each Done.
module instr_feeder #(
  parameter int         DEPTH  = 16,
  parameter int         AW     = 4,
  parameter logic [2:0] MVI_OP = 3'b001
) (
  input  logic              clk_i,
  input  logic              rst_i,
  instr_feeder_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_IMM   = 3'd2,
    S_WAIT  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  logic [15:0] mem_q [DEPTH];

  state_t      state_q, state_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] pc_q, pc_d;
  logic [15:0] din_q, din_d;
  logic        err_q, err_d;
  logic        fin_q, fin_d;

  logic [15:0] rd_word;
  logic        pc_lt_len;

  assign rd_word   = mem_q[pc_q[AW-1:0]];
  assign pc_lt_len = (pc_q < len_q);

  // Program memory survives reset so a program can be replayed after an abort.
  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE && bus.Wr_En) begin
      mem_q[bus.Wr_Addr] <= bus.Wr_Data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      pc_q    <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      din_q   <= din_d;
      err_q   <= err_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pc_d    = pc_q;
    din_d   = din_q;
    err_d   = err_q;
    fin_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          err_d = 1'b0;
          pc_d  = '0;
          if (bus.Len != '0) begin
            len_d   = bus.Len;
            state_d = S_ISSUE;
          end else begin
            fin_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        din_d   = rd_word;
        pc_d    = pc_q + 1'b1;
        state_d = (rd_word[15:13] == MVI_OP) ? S_IMM : S_WAIT;
      end
      S_IMM: begin
        state_d = S_WAIT;
        if (pc_lt_len) begin
          din_d = rd_word;
          pc_d  = pc_q + 1'b1;
        end else begin
          din_d = 16'h0000;
          err_d = 1'b1;
        end
      end
      // Done is only honoured here; a Done arriving during ISSUE/IMM belongs to an older instruction.
      S_WAIT: begin
        if (bus.Done) begin
`ifdef FEEDER_STEP_EN
          state_d = S_HOLD;
`else
          if (pc_lt_len) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
            fin_d   = 1'b1;
          end
`endif
        end
      end
`ifdef FEEDER_STEP_EN
      S_HOLD: begin
        if (bus.Step) begin
          if (pc_lt_len) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
            fin_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.DIN = din_q;
    bus.Run = 1'b0;
    case (state_q)
      S_ISSUE: begin
        bus.DIN = rd_word;
        bus.Run = !rst_i;
      end
      S_IMM:   bus.DIN = pc_lt_len ? rd_word : 16'h0000;
      default: ;
    endcase
  end

  assign bus.Busy     = (state_q != S_IDLE);
  assign bus.Finished = fin_q;
  assign bus.Error    = err_q;
  assign bus.PC       = pc_q;

endmodule
